// File: rtl/motor_emf_pkg.sv
// Shared constants and FSM state type for the motor back-EMF estimator and its inverse.
// All electrical quantities are unsigned fixed point with FRAC_BITS fractional bits.
package motor_emf_pkg;

  localparam int FRAC_BITS    = 8;
  localparam int RESIST       = 2030;
  localparam int CUR2VOL      = 640;
  localparam int BOARD_GAIN   = 9779;
  localparam int DIVISOR      = CUR2VOL * BOARD_GAIN;
  localparam int DIVISOR_BITS = 23;
  localparam int DIV_BITS     = 41;
  localparam int DIV_SHIFT    = 3 * FRAC_BITS - 1;
  localparam int CMD_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DIV,
    ST_DONE
  } emf_state_e;

endpackage

// File: rtl/seq_udiv.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// quotient/remainder present the result of the step in progress, so they are final while done=1.
module seq_udiv #(
  parameter int DW = 41,
  parameter int VW = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0] count;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic [VW:0]   partial;
  logic          fits;

  always_comb begin
    partial   = {rem_q, quo_q[DW-1]};
    fits      = (partial >= {1'b0, divisor});
    quotient  = {quo_q[DW-2:0], fits};
    remainder = fits ? VW'(partial - {1'b0, divisor}) : partial[VW-1:0];
  end

  assign done = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (start) begin
      count <= CW'(DW);
      quo_q <= dividend;
      rem_q <= '0;
    end else if (count != '0) begin
      count <= count - CW'(1);
      quo_q <= quotient;
      rem_q <= remainder;
    end
  end

endmodule

// File: rtl/motor_emf_to_cmd.sv
// Converts a desired back-EMF plus measured current into the DAC current command:
// cmd = (emf + cur_fb*R) * 2^23 / (CUR2VOL*BOARD_GAIN), saturated to 16 bits.
module motor_emf_to_cmd
  import motor_emf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                val_ready,
  input  logic [16:0]         emf_in,
  input  logic [15:0]         cur_fb,
  output logic                busy,
  output logic                cmd_ready,
  output logic [CMD_BITS-1:0] cmd_out,
  output logic                cmd_sat,
  output logic                cmd_err
);

  localparam logic [DIVISOR_BITS-1:0] DIVISOR_W = DIVISOR_BITS'(DIVISOR);

  emf_state_e state, state_next;

  logic                    val_last;
  logic                    start_edge;
  logic [16:0]             emf_lat;
  logic [15:0]             cur_lat;
  logic [15:0]             vol_res;
  logic [16:0]             sum;
  logic [DIV_BITS-1:0]     dividend;
  logic                    div_start;
  logic                    div_done;
  logic [DIV_BITS-1:0]     div_quo;
  logic [DIVISOR_BITS-1:0] div_rem;
  logic                    div_unused;

  assign start_edge = val_ready & ~val_last & (state == ST_IDLE);

  // The I*R drop is 8.24 after the multiply; dropping 16 bits leaves 8.8 volts.
  always_comb begin
    vol_res  = 16'((32'(cur_lat) * 32'(RESIST)) >> (2 * FRAC_BITS));
    sum      = {1'b0, emf_lat[15:0]} + {1'b0, vol_res};
    dividend = {1'b0, sum, {DIV_SHIFT{1'b0}}};
  end

  seq_udiv #(
    .DW(DIV_BITS),
    .VW(DIVISOR_BITS)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (DIVISOR_W),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign div_unused = ^div_rem;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: if (start_edge) state_next = ST_CALC;
      ST_CALC: begin
        if (emf_lat[16]) begin
          state_next = ST_DONE;
        end else begin
          div_start  = 1'b1;
          state_next = ST_DIV;
        end
      end
      ST_DIV:  if (div_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // History keeps following val_ready through reset, so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    val_last <= val_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      emf_lat <= '0;
      cur_lat <= '0;
      cmd_out <= '0;
      cmd_sat <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      if (start_edge) begin
        emf_lat <= emf_in;
        cur_lat <= cur_fb;
      end
      if (state == ST_CALC && emf_lat[16]) begin
        cmd_out <= '0;
        cmd_sat <= 1'b0;
        cmd_err <= 1'b1;
      end else if (state == ST_DIV && div_done) begin
        cmd_err <= 1'b0;
        if (|div_quo[DIV_BITS-1:CMD_BITS]) begin
          cmd_out <= '1;
          cmd_sat <= 1'b1;
        end else begin
          cmd_out <= div_quo[CMD_BITS-1:0];
          cmd_sat <= 1'b0;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign cmd_ready = (state == ST_DONE);

endmodule
